// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit that owns the HI/LO register pair.
// Multiplies are shift-add and divides are restoring shift-subtract.
// Each step handles one bit per cycle on operand magnitudes.
// Signs are applied afterwards in a two-cycle FIX phase:
//   - the first FIX cycle registers the sign-corrected result;
//   - the second FIX cycle accumulates (MADD/MSUB) and commits to HI/LO.
// The result is committed WIDTH+2 edges after start is accepted.
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic [2*WIDTH-1:0] hilo_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return (~x) + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic op_is_div(input logic [2:0] o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] o);
    return (o == OP_MULT) || (o == OP_DIV) || (o == OP_MADD) || (o == OP_MSUB);
  endfunction

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               a_neg_q, a_neg_d;
  logic               b_neg_q, b_neg_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               dz_q, dz_d;
  logic               fix2_q, fix2_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH:0]     mul_sum_s, div_shift_s, div_trial_s;
  logic               div_ok_s;
  logic [2*WIDTH-1:0] fix_res_s, commit_s;
  logic               fix_dz_s;

  // Operand magnitudes and one iteration step of the datapath.
  always_comb begin
    a_mag_s     = (op_is_signed(op) && a[WIDTH-1]) ? neg_w(a) : a;
    b_mag_s     = (op_is_signed(op) && b[WIDTH-1]) ? neg_w(b) : b;
    mul_sum_s   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    div_shift_s = {acc_hi_q, acc_lo_q[WIDTH-1]};
    // The remainder is always below the divisor, so a set top bit means the trial went negative.
    div_trial_s = div_shift_s - {1'b0, mcand_q};
    div_ok_s    = ~div_trial_s[WIDTH];
  end

  // Sign correction of the raw magnitude result, plus accumulate for MADD/MSUB.
  always_comb begin
    fix_res_s = {acc_hi_q, acc_lo_q};
    fix_dz_s  = 1'b0;
    if (op_is_div(op_q)) begin
      if (mcand_q == {WIDTH{1'b0}}) begin
        fix_res_s = {a_raw_q, {WIDTH{1'b1}}};
        fix_dz_s  = 1'b1;
      end else begin
        fix_res_s[WIDTH-1:0]       = (a_neg_q ^ b_neg_q) ? neg_w(acc_lo_q) : acc_lo_q;
        fix_res_s[2*WIDTH-1:WIDTH] = a_neg_q ? neg_w(acc_hi_q) : acc_hi_q;
      end
    end else begin
      fix_res_s = (a_neg_q ^ b_neg_q) ? neg_2w({acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};
    end
    case (op_q)
      OP_MADD: commit_s = {hi_q, lo_q} + res_q;
      OP_MSUB: commit_s = {hi_q, lo_q} - res_q;
      default: commit_s = res_q;
    endcase
  end

  // Next-state logic for the control FSM and the datapath registers.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_raw_d    = a_raw_q;
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
    mcand_d    = mcand_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    res_d      = res_q;
    dz_d       = dz_q;
    fix2_d     = fix2_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end else begin
            op_d       = op;
            a_raw_d    = a;
            a_neg_d    = op_is_signed(op) & a[WIDTH-1];
            b_neg_d    = op_is_signed(op) & b[WIDTH-1];
            acc_hi_d   = {WIDTH{1'b0}};
            acc_lo_d   = a_mag_s;
            mcand_d    = b_mag_s;
            cnt_d      = CNT_LOAD;
            div_zero_d = 1'b0;
            state_d    = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (op_is_div(op_q)) begin
            acc_hi_d = div_ok_s ? div_trial_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ok_s};
          end else begin
            acc_hi_d = mul_sum_s[WIDTH:1];
            acc_lo_d = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = S_FIX;
            fix2_d  = 1'b0;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (!fix2_q) begin
          res_d  = fix_res_s;
          dz_d   = fix_dz_s;
          fix2_d = 1'b1;
        end else begin
          {hi_d, lo_d} = commit_s;
          div_zero_d   = dz_q;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers; reset aborts any operation without touching HI/LO beyond clearing.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CW{1'b0}};
      op_q       <= 3'd0;
      a_raw_q    <= {WIDTH{1'b0}};
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      mcand_q    <= {WIDTH{1'b0}};
      acc_hi_q   <= {WIDTH{1'b0}};
      acc_lo_q   <= {WIDTH{1'b0}};
      res_q      <= {(2*WIDTH){1'b0}};
      dz_q       <= 1'b0;
      fix2_q     <= 1'b0;
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_raw_q    <= a_raw_d;
      a_neg_q    <= a_neg_d;
      b_neg_q    <= b_neg_d;
      mcand_q    <= mcand_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      res_q      <= res_d;
      dz_q       <= dz_d;
      fix2_q     <= fix2_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hilo_o   = {hi_q, lo_q};

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: behavioural reference model, per-cycle
// comparison, directed literal cases and randomized operations.
module tb_mdu_hilo;
  localparam int W = 32;
  localparam int LAT = W + 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done, div_zero;
  logic [2*W-1:0] hilo_o;

  int total = 0;
  int bad = 0;

  mdu_hilo #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .div_zero(div_zero), .hilo_o(hilo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result {div_zero, HI, LO} computed with plain integer arithmetic.
  function automatic logic [64:0] model_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, sq, sr;
    longint unsigned ux, uy, uq, ur;
    logic [63:0] r64;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    r64 = '0;
    case (o)
      3'd1: r64 = ux * uy;
      3'd2, 3'd3: begin
        if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
        if (o == 3'd2) begin
          sq = sx / sy; sr = sx % sy;
          r64 = {sr[31:0], sq[31:0]};
        end else begin
          uq = ux / uy; ur = ux % uy;
          r64 = {ur[31:0], uq[31:0]};
        end
      end
      default: r64 = sx * sy;
    endcase
    return {1'b0, r64};
  endfunction

  // Model state: architectural HI/LO plus a countdown to the commit edge.
  logic [31:0] m_hi, m_lo;
  logic        m_busy, m_done, m_dz, m_indone, p_dz;
  logic [2:0]  p_op;
  logic [63:0] p_res;
  int          m_left;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_indone <= 1'b0; m_left <= 0; p_op <= '0; p_res <= '0; p_dz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        if (flush) begin
          m_left <= 0; m_busy <= 1'b0;
        end else if (m_left == 1) begin
          case (p_op)
            3'd6:    {m_hi, m_lo} <= {m_hi, m_lo} + p_res;
            3'd7:    {m_hi, m_lo} <= {m_hi, m_lo} - p_res;
            default: {m_hi, m_lo} <= p_res;
          endcase
          m_done <= 1'b1; m_dz <= p_dz; m_left <= 0; m_indone <= 1'b1;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (m_indone) begin
        m_indone <= 1'b0; m_busy <= 1'b0;
      end else if (start && !flush) begin
        if (op == 3'd4) m_hi <= a;
        else if (op == 3'd5) m_lo <= a;
        else begin
          {p_dz, p_res} <= model_res(op, a, b);
          p_op <= op; m_dz <= 1'b0; m_busy <= 1'b1; m_left <= LAT;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (resetn) begin
      chk("cyc_busy", {63'd0, busy}, {63'd0, m_busy});
      chk("cyc_done", {63'd0, done}, {63'd0, m_done});
      chk("cyc_dz", {63'd0, div_zero}, {63'd0, m_dz});
      chk("cyc_hilo", hilo_o, {m_hi, m_lo});
    end
  end

  task automatic go(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (n < 100 && !done) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_lat"}, 64'(n), 64'(LAT));
  endtask

  task automatic run(input string nm, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [63:0] lit, input logic dz);
    go(o, x, y);
    wait_done(nm);
    chk(nm, hilo_o, lit);
    chk({nm, "_mdl"}, {m_hi, m_lo}, lit);
    chk({nm, "_dz"}, {63'd0, div_zero}, {63'd0, dz});
    @(posedge clk); #1;
  endtask

  logic [63:0] saved;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hilo", hilo_o, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    run("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    run("multu", 3'd1, 32'hFFFF_FFFD, 32'd7, 64'h0000_0006_FFFF_FFEB, 1'b0);
    run("divu", 3'd3, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0);
    run("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run("div_zero", 3'd2, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1'b1);

    go(3'd4, 32'd0, 32'd0);
    chk("mthi0", hilo_o, 64'h0000_0000_FFFF_FFFF);
    chk("mthi0_dz", {63'd0, div_zero}, 64'd1);
    go(3'd5, 32'd10, 32'd0);
    chk("mtlo10", hilo_o, 64'h0000_0000_0000_000A);
    run("madd", 3'd6, 32'hFFFF_FFFE, 32'd3, 64'h0000_0000_0000_0004, 1'b0);
    run("msub", 3'd7, 32'd1, 32'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run("min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
    run("divu_zero", 3'd3, 32'hDEAD_BEEF, 32'd0, 64'hDEAD_BEEF_FFFF_FFFF, 1'b1);

    // Flush in the tenth cycle of a divide: nothing is written.
    saved = hilo_o;
    go(3'd3, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_hilo", hilo_o, saved);
    repeat (40) begin @(posedge clk); #1; end
    chk("flush_hilo_late", hilo_o, saved);

    // Start held through a whole operation is taken again only once idle.
    op = 3'd1; a = 32'd2; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    wait_done("hold1");
    chk("hold1", hilo_o, 64'd10);
    @(posedge clk); #1;
    chk("hold_idle", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold_reaccept", {63'd0, busy}, 64'd1);
    wait_done("hold2");
    chk("hold2", hilo_o, 64'd10);
    @(posedge clk); #1;

    // start together with flush in IDLE is dropped.
    saved = hilo_o;
    op = 3'd5; a = 32'h1234; b = 32'd0; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    op = 3'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("sf_hilo", hilo_o, saved);
    chk("sf_busy", {63'd0, busy}, 64'd0);

    // Randomized operations with occasional flushes, checked every cycle.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  o;
      logic [31:0] x, y;
      int sel, fl;
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) y = 32'd0;
      else if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      else if (sel == 2) y = 32'($urandom_range(1, 20));
      go(o, x, y);
      fl = $urandom_range(0, 99);
      for (int c = 0; c < 36; c++) begin
        flush = (c == fl) ? 1'b1 : 1'b0;
        @(posedge clk); #1;
      end
      flush = 1'b0;
    end

    // Asynchronous reset in the middle of a multiply clears everything at once.
    go(3'd0, 32'd3, 32'd4);
    repeat (5) begin @(posedge clk); #1; end
    #2 resetn = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_hilo", hilo_o, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    run("post_rst", 3'd1, 32'd6, 32'd7, 64'd42, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair, generalising the single-cycle ALU's HI/LO move operations.
- Executes MULT/MULTU/DIV/DIVU/MADD/MSUB iteratively, one bit per cycle, and MTHI/MTLO in a single cycle.
- Sits beside the ALU in the EX stage. The pipeline stalls on busy, reads hilo_o for MFHI/MFLO, and drives flush on exception or branch squash.

Parameters:
- WIDTH, 32, operand width; must be even and ≥4; HI/LO are each WIDTH bits.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD (signed), 7 MSUB (signed)
- a  in  WIDTH  rs operand; dividend; MTHI/MTLO source
- b  in  WIDTH  rt operand; divisor
- flush  in  1  cancel any in-flight operation
- busy  out  1  high while an iterative op is in flight
- done  out  1  one-cycle pulse; HI/LO updated
- div_zero  out  1  valid with done; divisor was 0
- hilo_o  out  2*WIDTH  {HI,LO} register contents (registered, never combinational from inputs)

Behaviour:
- Reset (resetn=0, asynchronous): HI=LO=0, state IDLE, busy=0, done=0, div_zero=0, counter=0. Reset asserted mid-operation aborts the op with no HI/LO write.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1, flush=0, op 4/5: HI←a (MTHI) or LO←a (MTLO) at that edge. No busy, no done. State stays IDLE.
- IDLE, start=1, flush=0, op 0-3/6/7:
  - latch op, a, b, and |a|, |b| (magnitudes for signed ops; raw values for MULTU/DIVU);
  - load counter=WIDTH; go to CALC; busy=1 from the next cycle.
- CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle on magnitudes; counter decrements. When counter reaches 1 at an edge, go to FIX. CALC lasts exactly WIDTH cycles.
- FIX: apply signs.
  - Signed product: negated when a and b signs differ.
  - Signed quotient: negated when signs differ. Remainder takes the dividend's sign.
  - MADD: {HI,LO}+product. MSUB: {HI,LO}−product. Arithmetic is mod 2^(2*WIDTH) and uses HI/LO as held at this cycle.
  - Go to DONE.
- DONE: HI/LO written at the FIX→DONE edge; done=1 and busy=1 for this one cycle. Next edge: IDLE, busy=0.
- Latency: start sampled at edge 0 → done high in the cycle after edge WIDTH+2; hilo_o shows the result in the same cycle. With WIDTH=32, that is 34 cycles after start.
- Result placement: multiply → HI=upper, LO=lower product word. Divide → LO=quotient, HI=remainder.
- Divide by zero: div_zero=1 with done. HI=a (raw), LO=all-ones. Signed and unsigned divide produce the same result here.
- Signed DIV of MIN by −1: LO=MIN, HI=0. No flag.
- start while busy=1 is ignored entirely; requester must hold it. Same for start in DONE.
- MTHI/MTLO cannot occur while busy, so HI/LO are stable during an op.
- flush=1 in any non-IDLE state: no HI/LO write; next state IDLE; busy=0, done=0 next cycle. Flush in the DONE cycle does not undo the already-committed write.
- flush=1 with start=1 in IDLE: flush wins; the request is dropped, including MTHI/MTLO.
- div_zero clears to 0 when the next op is accepted.
- op is 3 bits, so every encoding is defined; no illegal-op handling.

Test Plan:
- Reset mid-CALC of MULT → busy=0, done=0, hilo_o=0 immediately, without waiting for a clock edge.
- MULT a=0xFFFFFFFD (−3), b=7 → busy for 34 cycles, then done pulse; hilo_o=0xFFFFFFFF_FFFFFFEB. MULTU same operands → 0x00000006_FFFFFFEB.
- DIVU a=100, b=7 → hilo_o=0x00000002_0000000E. DIV a=0xFFFFFFF9 (−7), b=2 → HI=0xFFFFFFFF, LO=0xFFFFFFFD.
- DIV a=5, b=0 → done with div_zero=1; HI=5, LO=0xFFFFFFFF. Following MTHI a=0 (idle) → HI=0 next cycle, no done pulse, div_zero unchanged.
- MTHI 0, MTLO 10, then MADD a=0xFFFFFFFE (−2), b=3 → hilo_o=0x00000000_00000004. MSUB a=1, b=5 → 0xFFFFFFFF_FFFFFFFF.
- Flush and busy-start cases:
  - DIVU started, flush at cycle 10 → IDLE next cycle, hilo_o unchanged, no done.
  - start held during busy → ignored; the next op is accepted the cycle after done.
  - start+flush together in IDLE → nothing accepted.
